// File: rtl/fft16_sched_pkg.sv
// Shared types and default widths for the 16-point FFT symbol scheduler.
package fft16_sched_pkg;

   localparam int unsigned DATA_WIDTH         = 16;
   localparam int unsigned DOUBLE_DATA_WIDTH  = 2 * DATA_WIDTH;
   localparam int unsigned NUM_PTS            = 16;

   localparam int unsigned FIFO_DEPTH_DEF     = 2;
   localparam int unsigned TIMEOUT_CYC_DEF    = 64;
   localparam int unsigned SYMS_PER_FRAME_DEF = 14;
   localparam int unsigned WDOG_W             = $clog2(TIMEOUT_CYC_DEF + 1);
   localparam int unsigned IDX_W              = $clog2(SYMS_PER_FRAME_DEF);

   // One complex sample {real, imag}; a symbol is 16 of them.
   typedef logic signed [DOUBLE_DATA_WIDTH-1:0] cplx_t;
   typedef cplx_t [NUM_PTS-1:0] sym16_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } sched_state_e;

endpackage

// File: rtl/fft16_sym_fifo.sv
// Small synchronous FIFO of whole FFT symbols with a combinational head output.
module fft16_sym_fifo
   import fft16_sched_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  sym16_t wr_data,
   output sym16_t rd_data,
   output logic   full,
   output logic   empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   sym16_t           mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
            wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

endmodule

// File: rtl/fft16_symbol_scheduler.sv
// Feeds buffered OFDM symbols one at a time into the FFT core, watches for a hung
// core, and hands each result to the equaliser through a valid/ready register.
module fft16_symbol_scheduler
   import fft16_sched_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
   parameter int unsigned TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
   parameter int unsigned SYMS_PER_FRAME = SYMS_PER_FRAME_DEF
) (
   input  logic                              i_clk_sched_fft16,
   input  logic                              i_rst,
   input  logic                              i_valid_sym,
   output logic                              o_ready_sym,
   input  sym16_t                            i_sym,
   output logic                              o_fft_start,
   output sym16_t                            o_fft_in,
   input  logic                              i_fft_done,
   input  sym16_t                            i_fft_out,
   output logic                              o_valid_out,
   input  logic                              i_ready_out,
   output sym16_t                            o_sym_out,
   output logic                              o_last_out,
   output logic [$clog2(SYMS_PER_FRAME)-1:0] o_sym_idx,
   output logic                              o_drop,
   output logic                              o_timeout_err,
   input  logic                              i_clr_err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned IX_W = $clog2(SYMS_PER_FRAME);

   sched_state_e    state_q, state_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic [IX_W-1:0] frame_idx_q;
   logic            rdy_en_q;
   logic            fifo_full, fifo_empty, fifo_push;
   logic            done_evt, tmo_evt, out_free;

   assign done_evt    = (state_q == WAIT_DONE) && i_fft_done;
   assign tmo_evt     = (state_q == WAIT_DONE) && !i_fft_done &&
                        (wdog_q == WD_W'(TIMEOUT_CYC - 1));
   assign out_free    = !o_valid_out || i_ready_out;
   assign o_ready_sym = rdy_en_q && !fifo_full;
   assign fifo_push   = i_valid_sym && o_ready_sym;

   fft16_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (i_clk_sched_fft16),
      .rst     (i_rst),
      .push    (fifo_push),
      .pop     (done_evt || tmo_evt),
      .wr_data (i_sym),
      .rd_data (o_fft_in),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge i_clk_sched_fft16 or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   // Start is gated on a free output register so a result can never be overwritten.
   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      case (state_q)
         IDLE:      if (!fifo_empty && out_free) state_d = START;
         START: begin
            wdog_d  = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (wdog_q != WD_W'(TIMEOUT_CYC)) wdog_d = wdog_q + WD_W'(1);
            if (done_evt || tmo_evt) state_d = IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_sched_fft16 or posedge i_rst) begin
      if (i_rst) begin
         rdy_en_q      <= 1'b0;
         o_fft_start   <= 1'b0;
         o_drop        <= 1'b0;
         o_timeout_err <= 1'b0;
         frame_idx_q   <= '0;
         o_valid_out   <= 1'b0;
         o_sym_out     <= '0;
         o_sym_idx     <= '0;
         o_last_out    <= 1'b0;
      end else begin
         rdy_en_q    <= 1'b1;
         o_fft_start <= (state_d == START);
         o_drop      <= tmo_evt;
         if (tmo_evt)        o_timeout_err <= 1'b1;
         else if (i_clr_err) o_timeout_err <= 1'b0;
         // Dropped symbols still consume a slot so frame alignment is kept.
         if (done_evt || tmo_evt) begin
            frame_idx_q <= (frame_idx_q == IX_W'(SYMS_PER_FRAME - 1)) ?
                           '0 : frame_idx_q + IX_W'(1);
         end
         if (done_evt) begin
            o_valid_out <= 1'b1;
            o_sym_out   <= i_fft_out;
            o_sym_idx   <= frame_idx_q;
            o_last_out  <= (frame_idx_q == IX_W'(SYMS_PER_FRAME - 1));
         end else if (i_ready_out) begin
            o_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft16_symbol_scheduler.sv
// Directed bench for the FFT symbol scheduler with a behavioural FFT core model.
module tb_fft16_symbol_scheduler;
   import fft16_sched_pkg::*;

   logic       clk = 1'b0;
   logic       i_rst, i_valid_sym, i_ready_out, i_clr_err, man_done;
   logic       o_ready_sym, o_fft_start, o_valid_out, o_last_out, o_drop, o_timeout_err;
   logic       i_fft_done;
   logic [3:0] o_sym_idx;
   sym16_t     i_sym, o_fft_in, i_fft_out, o_sym_out;

   int nerr = 0;
   int nchk = 0;

   // FFT core model: result = bitwise inverse of the symbol captured at start.
   int     fft_lat = 0;
   int     m_cnt = 0;
   int     unstable_cnt = 0;
   logic   m_done = 1'b0;
   sym16_t m_cap = '0;
   sym16_t m_out = '0;

   int start_cnt = 0;
   int drop_cnt = 0;
   sym16_t     res_d[$];
   logic [3:0] res_idx[$];
   logic       res_last[$];

   assign i_fft_done = m_done | man_done;
   assign i_fft_out  = m_out;

   always #5 clk = ~clk;

   fft16_symbol_scheduler dut (
      .i_clk_sched_fft16 (clk),
      .i_rst             (i_rst),
      .i_valid_sym       (i_valid_sym),
      .o_ready_sym       (o_ready_sym),
      .i_sym             (i_sym),
      .o_fft_start       (o_fft_start),
      .o_fft_in          (o_fft_in),
      .i_fft_done        (i_fft_done),
      .i_fft_out         (i_fft_out),
      .o_valid_out       (o_valid_out),
      .i_ready_out       (i_ready_out),
      .o_sym_out         (o_sym_out),
      .o_last_out        (o_last_out),
      .o_sym_idx         (o_sym_idx),
      .o_drop            (o_drop),
      .o_timeout_err     (o_timeout_err),
      .i_clr_err         (i_clr_err)
   );

   initial begin
      forever begin
         @(posedge clk);
         if (i_rst) m_cnt = 0;
         else if (o_fft_start && fft_lat > 0) begin
            m_cnt = fft_lat;
            m_cap = o_fft_in;
         end
         #1;
         m_done = 1'b0;
         if (m_cnt > 0) begin
            if (o_fft_in !== m_cap) unstable_cnt++;
            m_cnt--;
            if (m_cnt == 0) begin
               m_done = 1'b1;
               m_out  = ~m_cap;
            end
         end
      end
   end

   // Records every accepted result and counts start/drop pulses at the clock edge.
   always @(posedge clk) begin
      if (o_valid_out && i_ready_out) begin
         res_d.push_back(o_sym_out);
         res_idx.push_back(o_sym_idx);
         res_last.push_back(o_last_out);
      end
      if (o_fft_start) start_cnt++;
      if (o_drop) drop_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   function automatic sym16_t mk_sym(input int n);
      sym16_t s;
      for (int j = 0; j < 16; j++) s[j] = {16'(n * 37 + j), 16'(j * 5 - n)};
      return s;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sym(input int n, output bit ok);
      ok          = 1'b0;
      i_valid_sym = 1'b1;
      i_sym       = mk_sym(n);
      for (int c = 0; c < 300 && !ok; c++) begin
         if (o_ready_sym) ok = 1'b1;
         tick();
      end
      i_valid_sym = 1'b0;
   endtask

   task automatic wait_res(input int n, input int budget);
      for (int c = 0; c < budget && res_d.size() < n; c++) tick();
   endtask

   initial begin
      bit     ok, all_ok;
      int     lat, bad, base, s0, d0, bad_i, bad_l;
      sym16_t hold;

      i_rst = 1'b1; i_valid_sym = 1'b0; i_ready_out = 1'b1; i_clr_err = 1'b0;
      man_done = 1'b0; i_sym = '0;
      tick(); tick();
      chk("reset_flags", {o_ready_sym, o_fft_start, o_valid_out, o_last_out, o_drop, o_timeout_err, o_sym_idx}, 0);
      chk("reset_sym_out", o_sym_out, 0);
      i_rst = 1'b0;
      tick();
      chk("ready_after_reset", o_ready_sym, 1);

      // Single symbol, 20-cycle FFT
      fft_lat = 20;
      push_sym(0, ok);
      chk("push0", ok, 1);
      tick();
      chk("start_latency", o_fft_start, 1);
      lat = 0;
      for (int c = 0; c < 100 && !o_valid_out; c++) begin tick(); lat++; end
      chk("done_latency", lat, 21);
      chk("single_data", o_sym_out, ~mk_sym(0));
      chk("single_idx", o_sym_idx, 0);
      chk("single_last", o_last_out, 0);
      tick();
      chk("valid_clears_on_accept", o_valid_out, 0);
      chk("single_start_count", start_cnt, 1);
      chk("fft_in_stable", unstable_cnt, 0);

      // Three back-to-back symbols into a 2-deep FIFO
      base = res_d.size();
      push_sym(1, ok); chk("push1", ok, 1);
      push_sym(2, ok); chk("push2", ok, 1);
      chk("ready_low_when_full", o_ready_sym, 0);
      push_sym(3, ok); chk("push3", ok, 1);
      chk("ready_back_after_first_pop", res_d.size(), base + 1);
      wait_res(base + 3, 300);
      chk("b2b_count", res_d.size(), base + 3);
      for (int i = 0; i < 3; i++) begin
         chk("b2b_data", res_d[base + i], ~mk_sym(1 + i));
         chk("b2b_idx", res_idx[base + i], 1 + i);
      end

      // Downstream stall with a second symbol queued
      i_ready_out = 1'b0;
      base = res_d.size();
      push_sym(4, ok); chk("push4", ok, 1);
      push_sym(5, ok); chk("push5", ok, 1);
      for (int c = 0; c < 100 && !o_valid_out; c++) tick();
      chk("bp_valid", o_valid_out, 1);
      chk("bp_data", o_sym_out, ~mk_sym(4));
      hold = o_sym_out;
      s0 = start_cnt;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (!o_valid_out || o_sym_out !== hold || o_sym_idx !== 4'd4) bad++;
      end
      chk("bp_hold_stable", bad, 0);
      chk("bp_no_start", start_cnt, s0);
      i_ready_out = 1'b1;
      wait_res(base + 2, 200);
      chk("bp_count", res_d.size(), base + 2);
      chk("bp_second_data", res_d[base + 1], ~mk_sym(5));
      chk("bp_second_idx", res_idx[base + 1], 5);

      // Hung FFT core: drop 64 cycles after the start pulse is taken
      fft_lat = 0;
      d0 = drop_cnt;
      push_sym(6, ok); chk("push6", ok, 1);
      for (int c = 0; c < 10 && !o_fft_start; c++) tick();
      lat = 0;
      for (int c = 0; c < 100 && !o_drop; c++) begin tick(); lat++; end
      chk("timeout_latency", lat, 65);
      chk("timeout_err_set", o_timeout_err, 1);
      tick();
      chk("drop_is_pulse", o_drop, 0);
      chk("err_sticky", o_timeout_err, 1);
      fft_lat = 20;
      base = res_d.size();
      push_sym(7, ok); chk("push7", ok, 1);
      wait_res(base + 1, 200);
      chk("after_tmo_data", res_d[base], ~mk_sym(7));
      chk("after_tmo_idx", res_idx[base], 7);
      chk("err_held", o_timeout_err, 1);
      chk("single_drop", drop_cnt - d0, 1);
      i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
      chk("err_cleared", o_timeout_err, 0);

      // Done on the very cycle the watchdog expires: done wins
      fft_lat = 64;
      d0 = drop_cnt;
      base = res_d.size();
      push_sym(8, ok); chk("push8", ok, 1);
      wait_res(base + 1, 200);
      chk("tie_data", res_d[base], ~mk_sym(8));
      chk("tie_no_err", o_timeout_err, 0);
      chk("tie_no_drop", drop_cnt - d0, 0);

      // Reset while waiting on the core with the FIFO full
      fft_lat = 0;
      push_sym(9, ok); chk("push9", ok, 1);
      push_sym(10, ok); chk("push10", ok, 1);
      for (int c = 0; c < 5; c++) tick();
      chk("pre_reset_full", o_ready_sym, 0);
      #1 i_rst = 1'b1;
      #1;
      chk("async_reset_flags", {o_ready_sym, o_fft_start, o_valid_out, o_last_out, o_drop, o_timeout_err, o_sym_idx}, 0);
      chk("async_reset_fft_in", o_fft_in, 0);
      tick();
      i_rst = 1'b0;
      tick();
      chk("ready_after_mid_reset", o_ready_sym, 1);
      s0 = start_cnt;
      base = res_d.size();
      man_done = 1'b1; tick(); man_done = 1'b0; tick();
      chk("stray_done_ignored", o_valid_out, 0);
      chk("queue_flushed", start_cnt, s0);

      // Two full frames starting from index 0
      fft_lat = 5;
      all_ok = 1'b1;
      for (int n = 0; n < 28; n++) begin
         push_sym(100 + n, ok);
         all_ok &= ok;
      end
      chk("frame_pushes", all_ok, 1);
      wait_res(base + 28, 2000);
      chk("frame_count", res_d.size(), base + 28);
      bad = 0; bad_i = 0; bad_l = 0;
      for (int i = 0; i < 28 && base + i < res_d.size(); i++) begin
         if (res_d[base + i] !== ~mk_sym(100 + i)) bad++;
         if (res_idx[base + i] !== 4'(i % 14)) bad_i++;
         if (res_last[base + i] !== ((i % 14) == 13)) bad_l++;
      end
      chk("frame_data", bad, 0);
      chk("frame_idx_seq", bad_i, 0);
      chk("frame_last_seq", bad_l, 0);
      if (res_d.size() >= base + 28) begin
         chk("last_at_13", res_last[base + 13], 1);
         chk("wrap_to_0", res_idx[base + 14], 0);
         chk("last_at_27", res_last[base + 27], 1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
